// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_pkg;

   // Scoreboard rd field is sized for the widest supported register address.
   localparam int unsigned SB_RD_W = 8;

   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               is_load;
   } sb_entry_t;

   // Forward-select encodings (k = stage-k pipeline register).
   localparam int unsigned FWD_NONE  = 0;
   localparam int unsigned FWD_EXMEM = 1;
   localparam int unsigned FWD_MEMWB = 2;

   // MIPS primary opcodes relevant to hazard classification.
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

   // Stage at which a producer's result becomes forwardable.
   function automatic int unsigned ready_stage(input logic is_load, input int unsigned load_lat);
      return is_load ? (FWD_EXMEM + load_lat) : FWD_EXMEM;
   endfunction

endpackage

// File: rtl/pipe_hazard_unit_lookup.sv
// Priority search of the scoreboard for one ID source register.
module hazard_src_lookup
   import pipe_hazard_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned SEL_W      = 2
) (
   input  sb_entry_t [NUM_STAGES-1:0] sb,
   input  logic [REG_W-1:0]           src,
   input  logic                       src_used,
   output logic                       hazard,
   output logic [SEL_W-1:0]           sel
);

   logic found;

   // Youngest matching producer decides: forward from its stage or flag a hazard.
   always_comb begin
      hazard = 1'b0;
      sel    = SEL_W'(FWD_NONE);
      found  = 1'b0;
      if (src_used && (src != '0)) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (!found && sb[k].valid && (sb[k].rd == SB_RD_W'(src))) begin
               found = 1'b1;
               if ((k + 1) < ready_stage(sb[k].is_load, LOAD_LAT)) begin
                  hazard = 1'b1;
               end else begin
                  sel = SEL_W'(k + 1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control: scoreboard, select registers, counters.
module pipe_hazard_unit
   import pipe_hazard_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             pipe_hold,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   output logic             stall,
   output logic             bubble_ex,
   output logic             flush,
   output logic [SEL_W-1:0] fwd_sel_a,
   output logic [SEL_W-1:0] fwd_sel_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   sb_entry_t [NUM_STAGES-1:0] sb_q, sb_d;
   logic [SEL_W-1:0]           fwd_sel_a_q, fwd_sel_a_d;
   logic [SEL_W-1:0]           fwd_sel_b_q, fwd_sel_b_d;
   logic [CNT_W-1:0]           stall_count_q, stall_count_d;
   logic [CNT_W-1:0]           flush_count_q, flush_count_d;

   logic             hazard_a, hazard_b;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic             id_enter;

   hazard_src_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .REG_W      (REG_W),
      .LOAD_LAT   (LOAD_LAT),
      .SEL_W      (SEL_W)
   ) u_lookup_rs (
      .sb       (sb_q),
      .src      (id_rs),
      .src_used (id_rs_used),
      .hazard   (hazard_a),
      .sel      (sel_a)
   );

   hazard_src_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .REG_W      (REG_W),
      .LOAD_LAT   (LOAD_LAT),
      .SEL_W      (SEL_W)
   ) u_lookup_rt (
      .sb       (sb_q),
      .src      (id_rt),
      .src_used (id_rt_used),
      .hazard   (hazard_b),
      .sel      (sel_b)
   );

   // Same-cycle pipeline controls; hold masks everything, redirect beats stall.
   always_comb begin
      flush     = ex_redirect & ~pipe_hold;
      stall     = id_valid & (hazard_a | hazard_b) & ~ex_redirect & ~pipe_hold;
      bubble_ex = stall | flush;
      id_enter  = id_valid & id_wr_en & (id_rd != '0) & ~stall & ~flush;
   end

   // Scoreboard shift, select capture and saturating counters on each advance.
   always_comb begin
      sb_d          = sb_q;
      fwd_sel_a_d   = fwd_sel_a_q;
      fwd_sel_b_d   = fwd_sel_b_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!pipe_hold) begin
         for (int k = 1; k < int'(NUM_STAGES); k++) begin
            sb_d[k] = sb_q[k-1];
         end
         sb_d[0] = '0;
         if (id_enter) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].rd      = SB_RD_W'(id_rd);
            sb_d[0].is_load = id_is_load;
         end
         fwd_sel_a_d = bubble_ex ? SEL_W'(FWD_NONE) : sel_a;
         fwd_sel_b_d = bubble_ex ? SEL_W'(FWD_NONE) : sel_b;
         if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
         if (flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sb_q          <= '0;
         fwd_sel_a_q   <= '0;
         fwd_sel_b_q   <= '0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         sb_q          <= sb_d;
         fwd_sel_a_q   <= fwd_sel_a_d;
         fwd_sel_b_q   <= fwd_sel_b_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign fwd_sel_a   = fwd_sel_a_q;
   assign fwd_sel_b   = fwd_sel_b_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed table, parameter sweep, random vs. reference model.
module tb_pipe_hazard_unit;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pipe_hold, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, ex_redirect;
   logic [4:0] id_rs, id_rt, id_rd;

   logic        stall1, bubble1, flush1;
   logic [1:0]  sel1_a, sel1_b;
   logic [15:0] scnt1, fcnt1;
   logic        stall2, bubble2, flush2;
   logic [2:0]  sel2_a, sel2_b;
   logic [15:0] scnt2, fcnt2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pipe_hazard_unit #(.NUM_STAGES(2), .REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .pipe_hold(pipe_hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall(stall1), .bubble_ex(bubble1), .flush(flush1), .fwd_sel_a(sel1_a), .fwd_sel_b(sel1_b),
      .stall_count(scnt1), .flush_count(fcnt1)
   );

   pipe_hazard_unit #(.NUM_STAGES(4), .REG_W(5), .LOAD_LAT(2), .CNT_W(16)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .pipe_hold(pipe_hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall(stall2), .bubble_ex(bubble2), .flush(flush2), .fwd_sel_a(sel2_a), .fwd_sel_b(sel2_b),
      .stall_count(scnt2), .flush_count(fcnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: list of in-flight producers with ages ----------------
   typedef struct {
      int inst;
      int rd;
      bit ld;
      int age;
   } prod_t;

   prod_t hist[$];
   int    m_sa[2], m_sb[2], m_sc[2], m_fc[2];
   localparam int CMAX = 65535;

   function automatic int ns_of(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic int ll_of(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 2; i++) begin
         m_sa[i] = 0; m_sb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end
   endtask

   task automatic m_lookup(input int inst, input int src, input bit used, output bit hz, output int sel);
      int best_age;
      bit best_ld;
      best_age = 1000;
      best_ld  = 1'b0;
      hz  = 1'b0;
      sel = 0;
      if (used && src != 0) begin
         foreach (hist[j]) begin
            if (hist[j].inst == inst && hist[j].rd == src && hist[j].age < best_age) begin
               best_age = hist[j].age;
               best_ld  = hist[j].ld;
            end
         end
         if (best_age != 1000) begin
            if (best_age + 1 < (best_ld ? 1 + ll_of(inst) : 1)) hz = 1'b1;
            else sel = best_age + 1;
         end
      end
   endtask

   // Compare both DUTs with the model for the current inputs, then advance the model.
   task automatic model_cycle(input string tag);
      for (int i = 0; i < 2; i++) begin
         bit hza, hzb, m_stall, m_flush, enter;
         int sa, sb;
         logic [31:0] a_st, a_bu, a_fl, a_sa, a_sb, a_sc, a_fc;
         prod_t p;
         m_lookup(i, int'(id_rs), id_rs_used, hza, sa);
         m_lookup(i, int'(id_rt), id_rt_used, hzb, sb);
         m_flush = ex_redirect && !pipe_hold;
         m_stall = id_valid && (hza || hzb) && !ex_redirect && !pipe_hold;
         if (i == 0) begin
            a_st = 32'(stall1); a_bu = 32'(bubble1); a_fl = 32'(flush1);
            a_sa = 32'(sel1_a); a_sb = 32'(sel1_b); a_sc = 32'(scnt1); a_fc = 32'(fcnt1);
         end else begin
            a_st = 32'(stall2); a_bu = 32'(bubble2); a_fl = 32'(flush2);
            a_sa = 32'(sel2_a); a_sb = 32'(sel2_b); a_sc = 32'(scnt2); a_fc = 32'(fcnt2);
         end
         check($sformatf("%s dut%0d stall", tag, i + 1), a_st, 32'(m_stall));
         check($sformatf("%s dut%0d bubble_ex", tag, i + 1), a_bu, 32'(m_stall || m_flush));
         check($sformatf("%s dut%0d flush", tag, i + 1), a_fl, 32'(m_flush));
         check($sformatf("%s dut%0d fwd_sel_a", tag, i + 1), a_sa, m_sa[i]);
         check($sformatf("%s dut%0d fwd_sel_b", tag, i + 1), a_sb, m_sb[i]);
         check($sformatf("%s dut%0d stall_count", tag, i + 1), a_sc, m_sc[i]);
         check($sformatf("%s dut%0d flush_count", tag, i + 1), a_fc, m_fc[i]);
         if (!pipe_hold) begin
            for (int j = hist.size() - 1; j >= 0; j--) begin
               if (hist[j].inst == i) begin
                  p = hist[j];
                  p.age++;
                  if (p.age >= ns_of(i)) hist.delete(j);
                  else hist[j] = p;
               end
            end
            enter = id_valid && id_wr_en && id_rd != 0 && !m_stall && !m_flush;
            if (enter) begin
               p.inst = i; p.rd = int'(id_rd); p.ld = id_is_load; p.age = 0;
               hist.push_back(p);
            end
            m_sa[i] = (m_stall || m_flush) ? 0 : sa;
            m_sb[i] = (m_stall || m_flush) ? 0 : sb;
            if (m_stall && m_sc[i] < CMAX) m_sc[i]++;
            if (m_flush && m_fc[i] < CMAX) m_fc[i]++;
         end
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit hold, valid, ru, tu, wr, ld, redir;
      int rs, rt, rd;
      int e_stall, e_flush, e_sa, e_sb, e_sc, e_fc;
   } vec_t;

   function automatic vec_t row(input bit hold, input bit valid, input int rs, input int rt,
                                input bit ru, input bit tu, input bit wr, input int rd,
                                input bit ld, input bit redir, input int es, input int ef,
                                input int ea, input int eb, input int esc, input int efc);
      vec_t v;
      v.hold = hold; v.valid = valid; v.rs = rs; v.rt = rt; v.ru = ru; v.tu = tu;
      v.wr = wr; v.rd = rd; v.ld = ld; v.redir = redir;
      v.e_stall = es; v.e_flush = ef; v.e_sa = ea; v.e_sb = eb; v.e_sc = esc; v.e_fc = efc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      pipe_hold   = v.hold;
      id_valid    = v.valid;
      id_rs       = 5'(v.rs);
      id_rt       = 5'(v.rt);
      id_rs_used  = v.ru;
      id_rt_used  = v.tu;
      id_wr_en    = v.wr;
      id_rd       = 5'(v.rd);
      id_is_load  = v.ld;
      ex_redirect = v.redir;
   endtask

   vec_t tbl[31];
   vec_t idle;

   initial begin
      vec_t v;
      int base_sc2;
      //            hold vld rs rt ru tu wr rd ld rdr | stall flush sa sb scnt fcnt
      tbl[0]  = row(0, 1, 1, 2, 1, 1, 1, 3, 0, 0,   0, 0, 0, 0, 0, 0); // add r3,r1,r2
      tbl[1]  = row(0, 1, 3, 5, 1, 1, 1, 4, 0, 0,   0, 0, 0, 0, 0, 0); // sub r4,r3,r5
      tbl[2]  = row(0, 1, 3, 0, 1, 1, 1, 6, 0, 0,   0, 0, 1, 0, 0, 0); // or r6,r3,r0
      tbl[3]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0);
      tbl[4]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      tbl[5]  = row(0, 1, 1, 0, 1, 0, 1, 5, 1, 0,   0, 0, 0, 0, 0, 0); // lw r5
      tbl[6]  = row(0, 1, 5, 7, 1, 1, 1, 6, 0, 0,   1, 0, 0, 0, 0, 0); // add r6,r5,r7 stalls
      tbl[7]  = row(0, 1, 5, 7, 1, 1, 1, 6, 0, 0,   0, 0, 0, 0, 1, 0);
      tbl[8]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0);
      tbl[9]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
      tbl[10] = row(0, 1, 0, 0, 1, 0, 1, 2, 0, 0,   0, 0, 0, 0, 1, 0); // addi r2,r0
      tbl[11] = row(0, 1, 2, 0, 1, 0, 1, 2, 0, 0,   0, 0, 0, 0, 1, 0); // addi r2,r2
      tbl[12] = row(0, 1, 2, 2, 1, 1, 1, 8, 0, 0,   0, 0, 1, 0, 1, 0); // add r8,r2,r2
      tbl[13] = row(0, 1, 8, 0, 1, 0, 1, 0, 1, 0,   0, 0, 1, 1, 1, 0); // lw r0,(r8)
      tbl[14] = row(0, 1, 0, 0, 1, 1, 1, 9, 0, 0,   0, 0, 1, 0, 1, 0); // add r9,r0,r0
      tbl[15] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
      tbl[16] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
      tbl[17] = row(0, 1, 1, 0, 1, 0, 1, 5, 1, 0,   0, 0, 0, 0, 1, 0); // lw r5
      tbl[18] = row(0, 1, 5, 7, 1, 1, 1, 6, 0, 1,   0, 1, 0, 0, 1, 0); // hazard + redirect
      tbl[19] = row(0, 1, 6, 5, 1, 1, 1, 10, 0, 0,  0, 0, 0, 0, 1, 1); // r6 must be absent
      tbl[20] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 1);
      tbl[21] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
      tbl[22] = row(0, 1, 0, 0, 0, 0, 1, 11, 0, 0,  0, 0, 0, 0, 1, 1); // add r11
      tbl[23] = row(0, 1, 11, 0, 1, 0, 1, 5, 1, 0,  0, 0, 0, 0, 1, 1); // lw r5,(r11)
      tbl[24] = row(1, 1, 5, 7, 1, 1, 1, 6, 0, 0,   0, 0, 1, 0, 1, 1); // hold
      tbl[25] = row(1, 1, 5, 7, 1, 1, 1, 6, 0, 1,   0, 0, 1, 0, 1, 1); // hold + redirect
      tbl[26] = row(1, 1, 5, 7, 1, 1, 1, 6, 0, 0,   0, 0, 1, 0, 1, 1); // hold
      tbl[27] = row(0, 1, 5, 7, 1, 1, 1, 6, 0, 0,   1, 0, 1, 0, 1, 1); // stall resumes
      tbl[28] = row(0, 1, 5, 7, 1, 1, 1, 6, 0, 0,   0, 0, 0, 0, 2, 1);
      tbl[29] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 2, 1);
      tbl[30] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 1);
      idle    = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

      // Reset state
      reset_n = 1'b0;
      drive(idle);
      repeat (2) @(negedge clock);
      #1;
      check("reset stall", 32'(stall1), 0);
      check("reset flush", 32'(flush1), 0);
      check("reset sel_a", 32'(sel1_a), 0);
      check("reset stall_count", 32'(scnt1), 0);
      check("reset dut2 sel_b", 32'(sel2_b), 0);
      check("reset dut2 flush_count", 32'(fcnt2), 0);
      reset_n = 1'b1;
      model_reset();

      // Directed table
      for (int i = 0; i < 31; i++) begin
         @(negedge clock);
         drive(tbl[i]);
         #1;
         check($sformatf("tbl%0d stall", i), 32'(stall1), tbl[i].e_stall);
         check($sformatf("tbl%0d bubble_ex", i), 32'(bubble1), tbl[i].e_stall | tbl[i].e_flush);
         check($sformatf("tbl%0d flush", i), 32'(flush1), tbl[i].e_flush);
         check($sformatf("tbl%0d fwd_sel_a", i), 32'(sel1_a), tbl[i].e_sa);
         check($sformatf("tbl%0d fwd_sel_b", i), 32'(sel1_b), tbl[i].e_sb);
         check($sformatf("tbl%0d stall_count", i), 32'(scnt1), tbl[i].e_sc);
         check($sformatf("tbl%0d flush_count", i), 32'(fcnt1), tbl[i].e_fc);
         model_cycle($sformatf("tbl%0d", i));
      end

      // NUM_STAGES=4, LOAD_LAT=2: lw r9 then consumer -> two stalls, then select 3
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); drive(idle); #1; model_cycle("drain");
      end
      base_sc2 = m_sc[1];
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i == 0) v = row(0, 1, 0, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
         else if (i < 4) v = row(0, 1, 9, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else v = idle;
         drive(v);
         #1;
         check($sformatf("sweep%0d dut2 stall", i), 32'(stall2), (i == 1 || i == 2) ? 1 : 0);
         if (i == 4) begin
            check("sweep dut2 fwd_sel_a", 32'(sel2_a), 3);
            check("sweep dut2 stall_count", 32'(scnt2), 32'(base_sc2 + 2));
         end
         model_cycle($sformatf("sweep%0d", i));
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         pipe_hold   = ($urandom_range(0, 9) == 0);
         id_valid    = ($urandom_range(0, 9) != 0);
         id_rs       = 5'($urandom_range(0, 6));
         id_rt       = 5'($urandom_range(0, 6));
         id_rs_used  = ($urandom_range(0, 3) != 0);
         id_rt_used  = ($urandom_range(0, 2) != 0);
         id_wr_en    = ($urandom_range(0, 4) != 0);
         id_rd       = 5'($urandom_range(0, 6));
         id_is_load  = ($urandom_range(0, 2) == 0);
         ex_redirect = ($urandom_range(0, 11) == 0);
         #1;
         model_cycle($sformatf("rnd%0d", i));
      end

      // Reset pulse in the middle of a load-use stall
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); drive(idle); #1; model_cycle("drain2");
      end
      @(negedge clock);
      drive(row(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      #1; model_cycle("rst lw");
      @(negedge clock);
      drive(row(0, 1, 5, 7, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("pre-reset stall", 32'(stall1), 1);
      model_cycle("rst add");
      reset_n = 1'b0;
      #1;
      check("mid-reset stall", 32'(stall1), 0);
      check("mid-reset bubble_ex", 32'(bubble1), 0);
      check("mid-reset dut2 stall", 32'(stall2), 0);
      check("mid-reset fwd_sel_a", 32'(sel1_a), 0);
      check("mid-reset stall_count", 32'(scnt1), 0);
      check("mid-reset flush_count", 32'(fcnt1), 0);
      check("mid-reset dut2 stall_count", 32'(scnt2), 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      drive(idle);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1; model_cycle("post-reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
